regfile_sb: RTL and testbench

Parametrised integer register file for the core's ID stage. It has two combinational read ports and one write port, with register 0 hardwired to zero. A per-register pending-write scoreboard supports hazard detection, and a sequential clear engine zeroes the file at runtime without a reset. It replaces fixed-size mux-tree register banks, with depth and width set by parameters.

---
 rtl/regfile_sb.sv | 140 ++++++++++++++
 tb/tb_regfile_sb.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
// Integer register file for the ID stage.
//   - two combinational read ports, one write port, register 0 reads as zero
//   - per-register pending-write scoreboard for hazard detection
//   - sequential clear engine that zeroes the file at runtime without a reset
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   : a qualifying write is forwarded to a read port with the same
//               address in the same cycle
//   undefined : reads always return array contents
//
// Ports
//   clk                    clock, rising edge
//   reset                  asynchronous active-low reset
//   rs1_addr, rs2_addr     read addresses
//   rs1_data, rs2_data     combinational read data
//   rs1_pending,rs2_pending scoreboard bit of the addressed register (registered)
//   wr_en/wr_addr/wr_data  write port
//   issue_en/issue_addr    marks a destination as having an in-flight write
//   clr_start              request a runtime clear of the whole file
//   busy                   clear engine active
//   clr_done               one-cycle pulse after a clear completes
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | normal operation; writes and issues accepted
// ST_CLEAR | zeroing reg[idx] each cycle; writes/issues/clr_start ignored
// -----------------------------------------------------------------------------
module regfile_sb #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_pending,
  output logic            rs2_pending,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            issue_en,
  input  logic [AW-1:0]   issue_addr,
  input  logic            clr_start,
  output logic            busy,
  output logic            clr_done
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;
  localparam logic [5:0] IDX_LAST = 6'(NREGS - 1);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] pending_q, pending_d;
  logic [0:0]       state_q, state_d;
  logic [5:0]       idx_q, idx_d;
  logic             clr_done_q, clr_done_d;

  logic idle;
  logic wr_ok;
  logic iss_ok;

  assign idle   = (state_q == ST_IDLE);
  assign wr_ok  = wr_en    && (wr_addr    != '0) && idle;
  assign iss_ok = issue_en && (issue_addr != '0) && idle;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    clr_done_d = 1'b0;
    pending_d  = pending_q;
    regs_d     = regs_q;

    case (state_q)
      ST_IDLE: begin
        if (wr_ok) regs_d[wr_addr] = wr_data;
        if (clr_start) begin
          state_d   = ST_CLEAR;
          idx_d     = 6'd1;
          pending_d = '0;
        end else begin
          // Clear first so that a same-cycle issue to the same register wins.
          if (wr_ok)  pending_d[wr_addr]    = 1'b0;
          if (iss_ok) pending_d[issue_addr] = 1'b1;
        end
      end
      ST_CLEAR: begin
        regs_d[idx_q[AW-1:0]] = '0;
        idx_d = idx_q + 6'd1;
        if (idx_q == IDX_LAST) begin
          state_d    = ST_IDLE;
          idx_d      = '0;
          clr_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    regs_d[0]    = '0;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      pending_q  <= '0;
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      clr_done_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      pending_q  <= pending_d;
      state_q    <= state_d;
      idx_q      <= idx_d;
      clr_done_q <= clr_done_d;
    end
  end

  // Read ports. The bypass is gated by reset so outputs stay zero while
  // reset is held even if a write strobe is present.
  always_comb begin
    rs1_data = (rs1_addr == '0) ? '0 : regs_q[rs1_addr];
    rs2_data = (rs2_addr == '0) ? '0 : regs_q[rs2_addr];
`ifdef REGFILE_BYPASS_EN
    if (reset && wr_ok && (rs1_addr == wr_addr)) rs1_data = wr_data;
    if (reset && wr_ok && (rs2_addr == wr_addr)) rs2_data = wr_data;
`endif
  end

  assign rs1_pending = pending_q[rs1_addr];
  assign rs2_pending = pending_q[rs2_addr];
  assign busy        = (state_q == ST_CLEAR);
  assign clr_done    = clr_done_q;

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk;
  logic            reset;
  logic [AW-1:0]   rs1_addr, rs2_addr;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic            rs1_pending, rs2_pending;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;
  logic            issue_en;
  logic [AW-1:0]   issue_addr;
  logic            clr_start;
  logic            busy, clr_done;

  int checks   = 0;
  int failures = 0;

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clk(clk), .reset(reset),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_pending(rs1_pending), .rs2_pending(rs2_pending),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .clr_start(clr_start), .busy(busy), .clr_done(clr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hFFFF_FFFF;
    issue_en = 1'b1; issue_addr = 5'd5;
    tick(); tick();
    for (int i = 0; i < NREGS; i++) begin
      rs1_addr = AW'(i); rs2_addr = AW'(NREGS - 1 - i);
      #1;
      checks++;
      if (rs1_data !== '0 || rs2_data !== '0) begin
        failures++;
        $display("FAIL reset_data addr=%0d got rs1=%h rs2=%h want 0", i, rs1_data, rs2_data);
      end
      checks++;
      if (rs1_pending !== 1'b0 || rs2_pending !== 1'b0) begin
        failures++;
        $display("FAIL reset_pending addr=%0d got %b/%b want 0/0", i, rs1_pending, rs2_pending);
      end
    end
    checks++;
    if (busy !== 1'b0 || clr_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl got busy=%b clr_done=%b want 0/0", busy, clr_done);
    end
    wr_en = 1'b0; issue_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_x0();
    wr_en = 1'b1; wr_addr = '0; wr_data = 32'hDEAD_BEEF; rs1_addr = '0;
    issue_en = 1'b1; issue_addr = '0; rs2_addr = '0;
    #1;
    checks++;
    if (rs1_data !== '0) begin
      failures++;
      $display("FAIL x0_same_cycle got %h want 0", rs1_data);
    end
    tick();
    wr_en = 1'b0; issue_en = 1'b0;
    #1;
    checks++;
    if (rs1_data !== '0) begin
      failures++;
      $display("FAIL x0_read got %h want 0", rs1_data);
    end
    checks++;
    if (rs2_pending !== 1'b0) begin
      failures++;
      $display("FAIL x0_pending got %b want 0", rs2_pending);
    end
  endtask

  task automatic test_bypass();
    rs1_addr = 5'd5; rs2_addr = 5'd6;
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h1234_5678;
    #1;
    checks++;
    if (rs1_data !== (BYP ? 32'h1234_5678 : 32'h0)) begin
      failures++;
      $display("FAIL write_same_cycle got %h want %h", rs1_data, BYP ? 32'h1234_5678 : 32'h0);
    end
    checks++;
    if (rs2_data !== 32'h0) begin
      failures++;
      $display("FAIL other_port_no_bypass got %h want 0", rs2_data);
    end
    tick();
    wr_en = 1'b0;
    #1;
    checks++;
    if (rs1_data !== 32'h1234_5678) begin
      failures++;
      $display("FAIL write_next_cycle got %h want 12345678", rs1_data);
    end
  endtask

  task automatic test_scoreboard();
    rs1_addr = 5'd7; rs2_addr = 5'd7;
    issue_en = 1'b1; issue_addr = 5'd7;
    #1;
    checks++;
    if (rs2_pending !== 1'b0) begin
      failures++;
      $display("FAIL pending_not_bypassed got %b want 0", rs2_pending);
    end
    tick();
    issue_en = 1'b0;
    #1;
    checks++;
    if (rs2_pending !== 1'b1 || rs1_pending !== 1'b1) begin
      failures++;
      $display("FAIL issue_sets got %b/%b want 1/1", rs1_pending, rs2_pending);
    end
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h77;
    tick();
    wr_en = 1'b0;
    #1;
    checks++;
    if (rs2_pending !== 1'b0) begin
      failures++;
      $display("FAIL write_clears got %b want 0", rs2_pending);
    end
    issue_en = 1'b1; issue_addr = 5'd7;
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h78;
    tick();
    issue_en = 1'b0; wr_en = 1'b0;
    #1;
    checks++;
    if (rs2_pending !== 1'b1) begin
      failures++;
      $display("FAIL set_wins got %b want 1", rs2_pending);
    end
  endtask

  task automatic test_clear();
    int cnt;
    for (int i = 1; i < NREGS; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = 32'h1000_0000 | (i * 17);
      tick();
    end
    wr_en = 1'b0;
    rs1_addr = 5'd31; rs2_addr = 5'd1;
    #1;
    checks++;
    if (rs1_data !== 32'h1000_020F || rs2_data !== 32'h1000_0011) begin
      failures++;
      $display("FAIL fill got %h/%h want 1000020f/10000011", rs1_data, rs2_data);
    end
    issue_en = 1'b1; issue_addr = 5'd2; tick();
    issue_addr = 5'd9; tick();
    issue_en = 1'b0;
    rs1_addr = 5'd2; rs2_addr = 5'd9;
    #1;
    checks++;
    if (rs1_pending !== 1'b1 || rs2_pending !== 1'b1) begin
      failures++;
      $display("FAIL pre_clear_pending got %b/%b want 1/1", rs1_pending, rs2_pending);
    end
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    #1;
    checks++;
    if (rs1_pending !== 1'b0 || rs2_pending !== 1'b0) begin
      failures++;
      $display("FAIL clear_pending got %b/%b want 0/0", rs1_pending, rs2_pending);
    end
    rs1_addr = 5'd6;
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      if (cnt == 5) begin
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hBAD0_0003;
        issue_en = 1'b1; issue_addr = 5'd6; clr_start = 1'b1;
      end else begin
        wr_en = 1'b0; issue_en = 1'b0; clr_start = 1'b0;
      end
      tick();
    end
    wr_en = 1'b0; issue_en = 1'b0; clr_start = 1'b0;
    checks++;
    if (cnt != NREGS - 1) begin
      failures++;
      $display("FAIL busy_len got %0d want %0d", cnt, NREGS - 1);
    end
    checks++;
    if (clr_done !== 1'b1) begin
      failures++;
      $display("FAIL clr_done_pulse got %b want 1", clr_done);
    end
    checks++;
    if (rs1_pending !== 1'b0) begin
      failures++;
      $display("FAIL issue_during_busy got %b want 0", rs1_pending);
    end
    tick();
    checks++;
    if (clr_done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL post_clear got clr_done=%b busy=%b want 0/0", clr_done, busy);
    end
    for (int i = 0; i < NREGS; i++) begin
      rs1_addr = AW'(i); rs2_addr = AW'(NREGS - 1 - i);
      #1;
      checks++;
      if (rs1_data !== '0 || rs2_data !== '0) begin
        failures++;
        $display("FAIL cleared_data addr=%0d got %h/%h want 0", i, rs1_data, rs2_data);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    bit bad;
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h55;
    tick();
    wr_en = 1'b0;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (9) tick();
    #2;
    reset = 1'b0;
    rs1_addr = 5'd4;
    #1;
    checks++;
    if (busy !== 1'b0 || clr_done !== 1'b0) begin
      failures++;
      $display("FAIL abort_immediate got busy=%b clr_done=%b want 0/0", busy, clr_done);
    end
    checks++;
    if (rs1_data !== '0) begin
      failures++;
      $display("FAIL abort_data got %h want 0", rs1_data);
    end
    tick();
    @(negedge clk);
    reset = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (busy !== 1'b0 || clr_done !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL no_clr_done_after_abort got activity want none");
    end
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'hA5;
    tick();
    wr_en = 1'b0;
    #1;
    checks++;
    if (rs1_data !== 32'hA5) begin
      failures++;
      $display("FAIL write_after_reset got %h want a5", rs1_data);
    end
  endtask

  initial begin
    reset = 1'b0;
    rs1_addr = '0; rs2_addr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    issue_en = 1'b0; issue_addr = '0;
    clr_start = 1'b0;
    #3;
    test_reset();
    test_x0();
    test_bypass();
    test_scoreboard();
    test_clear();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
